// File: rtl/fft_pkg.sv
// Shared FFT datapath types and fixed-point helpers: complex packing, twiddle Q-format,
// round-half-up shift and range clamp on a wide signed accumulator.
package fft_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_H     = DEF_WIDTH / 2;
  localparam int TW_FRAC   = DEF_H - 1;
  localparam int ACC_W     = 64;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic signed [DEF_H-1:0] re;
    logic signed [DEF_H-1:0] im;
  } complex_t;

  function automatic acc_t half_limit(input int h);
    return acc_t'(1) <<< (h - 1);
  endfunction

  // Round half up, then arithmetic shift; frac must be at least 1.
  function automatic acc_t round_shift(input acc_t x, input int frac);
    acc_t half;
    half = acc_t'(1) <<< (frac - 1);
    return (x + half) >>> frac;
  endfunction

  function automatic logic out_of_range(input acc_t s, input int h);
    acc_t lim;
    lim = half_limit(h);
    return (s < -lim) || (s > lim - acc_t'(1));
  endfunction

  function automatic acc_t saturate(input acc_t s, input int h, input logic en);
    acc_t lim;
    lim = half_limit(h);
    if (en && (s < -lim)) return -lim;
    if (en && (s > lim - acc_t'(1))) return lim - acc_t'(1);
    return s;
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Complex multiply B*W (or B*conj(W)) registered as four partial products, followed by the
// combine and round-half-up shift back to H+2 bits.
module cmul_round
  import fft_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = WIDTH / 2 - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH-1:0]           w,
  input  logic                       inverse,
  output logic signed [WIDTH/2+1:0]  p_re,
  output logic signed [WIDTH/2+1:0]  p_im
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * H + 1;

  logic signed [H-1:0]  b_re, b_im, w_re, w_im;
  logic signed [H:0]    w_im_eff;
  logic signed [PW-1:0] rr_d, ii_d, ir_d, ri_d;
  logic signed [PW-1:0] rr_q, ii_q, ir_q, ri_q;
  acc_t                 pr_full, pi_full, pr_rnd, pi_rnd;
  logic [ACC_W-H-3:0]   pr_unused, pi_unused;

  always_comb begin
    b_re = b[WIDTH-1:H];
    b_im = b[H-1:0];
    w_re = w[WIDTH-1:H];
    w_im = w[H-1:0];
    // One extra bit so that conj of the most negative Wi stays exact.
    w_im_eff = inverse ? -(H+1)'(w_im) : (H+1)'(w_im);
    rr_d = PW'(b_re) * PW'(w_re);
    ii_d = PW'(b_im) * PW'(w_im_eff);
    ir_d = PW'(b_im) * PW'(w_re);
    ri_d = PW'(b_re) * PW'(w_im_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      ii_q <= '0;
      ir_q <= '0;
      ri_q <= '0;
    end else if (en) begin
      rr_q <= rr_d;
      ii_q <= ii_d;
      ir_q <= ir_d;
      ri_q <= ri_d;
    end
  end

  always_comb begin
    pr_full = acc_t'(rr_q) - acc_t'(ii_q);
    pi_full = acc_t'(ir_q) + acc_t'(ri_q);
    pr_rnd  = round_shift(pr_full, FRAC);
    pi_rnd  = round_shift(pi_full, FRAC);
    {pr_unused, p_re} = pr_rnd;
    {pi_unused, p_im} = pi_rnd;
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly with a stream interface: operands in S1, partial
// products in S2, add/sub, optional halving and clamp/wrap in S3 (the output register).
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = WIDTH / 2 - 1,
  parameter int TAG_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_twiddle,
  input  logic             in_inverse,
  input  logic             in_scale,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_add,
  output logic [WIDTH-1:0] out_sub,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf_sticky,
  input  logic             ovf_clear
);

  localparam int H = WIDTH / 2;

  // Handshake: a beat moves on a cycle where valid and ready are both high. The whole
  // pipe advances together whenever the output slot is empty or being drained, so
  // in_ready is that advance term and out_* stay frozen while out_valid waits on out_ready.
  logic advance;

  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q, s1_w_d, s1_w_q;
  logic             s1_inv_d, s1_inv_q, s1_scale_d, s1_scale_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

  logic             s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0] s2_a_d, s2_a_q;
  logic             s2_scale_d, s2_scale_q;
  logic [TAG_W-1:0] s2_tag_d, s2_tag_q;

  logic             s3_valid_d, s3_valid_q;
  logic [WIDTH-1:0] s3_add_d, s3_add_q, s3_sub_d, s3_sub_q;
  logic [TAG_W-1:0] s3_tag_d, s3_tag_q;
  logic             s3_ovf_d, s3_ovf_q;
  logic             ovf_sticky_d, ovf_sticky_q;

  logic signed [H+1:0] p_re, p_im;
  logic signed [H-1:0] a_re, a_im;
  acc_t                comp [4];
  logic [ACC_W-H-1:0]  res_unused [4];
  logic [H-1:0]        res [4];
  logic                ovf_any;

  assign advance  = !s3_valid_q || out_ready;
  assign in_ready = advance;

  cmul_round #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (advance && s1_valid_q),
    .b       (s1_b_q),
    .w       (s1_w_q),
    .inverse (s1_inv_q),
    .p_re    (p_re),
    .p_im    (p_im)
  );

  // Order in comp/res: add.re, add.im, sub.re, sub.im.
  always_comb begin
    a_re    = s2_a_q[WIDTH-1:H];
    a_im    = s2_a_q[H-1:0];
    comp[0] = acc_t'(a_re) + acc_t'(p_re);
    comp[1] = acc_t'(a_im) + acc_t'(p_im);
    comp[2] = acc_t'(a_re) - acc_t'(p_re);
    comp[3] = acc_t'(a_im) - acc_t'(p_im);
    ovf_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s2_scale_q) comp[i] = (comp[i] + acc_t'(1)) >>> 1;
      ovf_any = ovf_any | out_of_range(comp[i], H);
      {res_unused[i], res[i]} = saturate(comp[i], H, SATURATE != 0);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_w_d     = s1_w_q;
    s1_inv_d   = s1_inv_q;
    s1_scale_d = s1_scale_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_scale_d = s2_scale_q;
    s2_tag_d   = s2_tag_q;
    s3_valid_d = s3_valid_q;
    s3_add_d   = s3_add_q;
    s3_sub_d   = s3_sub_q;
    s3_tag_d   = s3_tag_q;
    s3_ovf_d   = s3_ovf_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_w_d     = in_twiddle;
        s1_inv_d   = in_inverse;
        s1_scale_d = in_scale;
        s1_tag_d   = in_tag;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_a_d     = s1_a_q;
        s2_scale_d = s1_scale_q;
        s2_tag_d   = s1_tag_q;
      end
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_add_d = {res[0], res[1]};
        s3_sub_d = {res[2], res[3]};
        s3_tag_d = s2_tag_q;
        s3_ovf_d = ovf_any;
      end
    end
    // A new overflow on the output handshake beats a simultaneous clear.
    if (s3_valid_q && out_ready && s3_ovf_q) ovf_sticky_d = 1'b1;
    else if (ovf_clear)                      ovf_sticky_d = 1'b0;
    else                                     ovf_sticky_d = ovf_sticky_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_w_q       <= '0;
      s1_inv_q     <= 1'b0;
      s1_scale_q   <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_a_q       <= '0;
      s2_scale_q   <= 1'b0;
      s2_tag_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_add_q     <= '0;
      s3_sub_q     <= '0;
      s3_tag_q     <= '0;
      s3_ovf_q     <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_w_q       <= s1_w_d;
      s1_inv_q     <= s1_inv_d;
      s1_scale_q   <= s1_scale_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_a_q       <= s2_a_d;
      s2_scale_q   <= s2_scale_d;
      s2_tag_q     <= s2_tag_d;
      s3_valid_q   <= s3_valid_d;
      s3_add_q     <= s3_add_d;
      s3_sub_q     <= s3_sub_d;
      s3_tag_q     <= s3_tag_d;
      s3_ovf_q     <= s3_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_add    = s3_add_q;
  assign out_sub    = s3_sub_q;
  assign out_tag    = s3_tag_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Stream bench for butterfly_pipe: saturating and wrapping instances share stimulus and are
// scored against an integer model of the butterfly arithmetic.
module tb_butterfly_pipe;
  import fft_pkg::*;

  localparam int WIDTH = 32;
  localparam int H     = 16;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_inverse, in_scale, out_ready, ovf_clear;
  logic [WIDTH-1:0] in_a, in_b, in_twiddle;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready, out_valid, ovf_sticky;
  logic [WIDTH-1:0] out_add, out_sub;
  logic [TAG_W-1:0] out_tag;
  logic             w_in_ready, w_out_valid, w_ovf_sticky;
  logic [WIDTH-1:0] w_out_add, w_out_sub;
  logic [TAG_W-1:0] w_out_tag;

  typedef struct packed {
    logic [WIDTH-1:0] add_s;
    logic [WIDTH-1:0] sub_s;
    logic [WIDTH-1:0] add_w;
    logic [WIDTH-1:0] sub_w;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;
  logic exp_ovf  = 1'b0;
  logic xfer_ovf;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  butterfly_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_twiddle(in_twiddle), .in_inverse(in_inverse),
    .in_scale(in_scale), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_add(out_add), .out_sub(out_sub), .out_tag(out_tag),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  butterfly_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_twiddle(in_twiddle), .in_inverse(in_inverse),
    .in_scale(in_scale), .in_tag(in_tag), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_add(w_out_add), .out_sub(w_out_sub), .out_tag(w_out_tag),
    .ovf_sticky(w_ovf_sticky), .ovf_clear(ovf_clear)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [WIDTH-1:0] a, b, w, input logic inv, scale,
                                 input logic [TAG_W-1:0] tag);
    complex_t ca, cb, cw;
    longint   ar, ai, br, bi, wr, wi, pr, pi;
    longint   s[4];
    logic [H-1:0] sat16[4];
    logic [H-1:0] wrap16[4];
    exp_t e;
    ca = a; cb = b; cw = w;
    ar = longint'(ca.re); ai = longint'(ca.im);
    br = longint'(cb.re); bi = longint'(cb.im);
    wr = longint'(cw.re); wi = longint'(cw.im);
    if (inv) wi = -wi;
    pr = br * wr - bi * wi;
    pi = bi * wr + br * wi;
    pr = (pr + (longint'(1) <<< (TW_FRAC - 1))) >>> TW_FRAC;
    pi = (pi + (longint'(1) <<< (TW_FRAC - 1))) >>> TW_FRAC;
    s[0] = ar + pr; s[1] = ai + pi; s[2] = ar - pr; s[3] = ai - pi;
    e.ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (scale) s[i] = (s[i] + 1) >>> 1;
      wrap16[i] = H'(s[i]);
      if (s[i] > 32767) begin
        sat16[i] = 16'h7FFF; e.ovf = 1'b1;
      end else if (s[i] < -32768) begin
        sat16[i] = 16'h8000; e.ovf = 1'b1;
      end else begin
        sat16[i] = H'(s[i]);
      end
    end
    e.add_s = {sat16[0], sat16[1]};
    e.sub_s = {sat16[2], sat16[3]};
    e.add_w = {wrap16[0], wrap16[1]};
    e.sub_w = {wrap16[2], wrap16[3]};
    e.tag   = tag;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else               out_ready = (rdy_mode == 0);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [WIDTH-1:0] a, b, w, input logic inv, scale,
                           input logic [TAG_W-1:0] tag);
    bit accepted = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_twiddle = w;
    in_inverse = inv; in_scale = scale; in_tag = tag;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, w, inv, scale, tag));
        accepted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!accepted) chk("send_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] a, b, w,
                          input logic inv, scale,
                          input logic [WIDTH-1:0] e_add, e_sub, e_add_w);
    int lat = 0;
    send_beat(a, b, w, inv, scale, 8'hA5);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    chk({name, "_latency"}, 64'(lat), 64'd3);
    chk({name, "_add"}, 64'(out_add), 64'(e_add));
    chk({name, "_sub"}, 64'(out_sub), 64'(e_sub));
    chk({name, "_add_wrap"}, 64'(w_out_add), 64'(e_add_w));
    chk({name, "_sub_wrap"}, 64'(w_out_sub), 64'(e_sub));
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ovf = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      chk("ovf_sticky", 64'(ovf_sticky), 64'(exp_ovf));
      chk("ovf_sticky_wrap", 64'(w_ovf_sticky), 64'(exp_ovf));
      chk("valid_wrap", 64'(w_out_valid), 64'(out_valid));
      xfer_ovf = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_add", 64'(out_add), 64'(mon_e.add_s));
          chk("out_sub", 64'(out_sub), 64'(mon_e.sub_s));
          chk("out_tag", 64'(out_tag), 64'(mon_e.tag));
          chk("wrap_add", 64'(w_out_add), 64'(mon_e.add_w));
          chk("wrap_sub", 64'(w_out_sub), 64'(mon_e.sub_w));
          chk("wrap_tag", 64'(w_out_tag), 64'(mon_e.tag));
          xfer_ovf = mon_e.ovf;
        end
      end
      if (xfer_ovf)       exp_ovf = 1'b1;
      else if (ovf_clear) exp_ovf = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] ra, rb, rw;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_twiddle = '0;
    in_inverse = 1'b0; in_scale = 1'b0; in_tag = '0; out_ready = 1'b1; ovf_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);
    chk("rst_out_add", 64'(out_add), 64'd0);
    chk("rst_out_sub", 64'(out_sub), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_wrap_valid", 64'(w_out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("t1", 32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0,
             32'h6000_0000, 32'h2000_0000, 32'h6000_0000);
    directed("t2_sat", 32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b0,
             32'h7FFF_0000, 32'h0001_0000, 32'hDFFF_0000);
    chk("t2_ovf_set", 64'(ovf_sticky), 64'd1);
    ovf_clear = 1'b1; @(posedge clk); #1; ovf_clear = 1'b0;
    directed("t2_scale", 32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b1,
             32'h7000_0000, 32'h0001_0000, 32'h7000_0000);
    chk("t2_scale_ovf", 64'(ovf_sticky), 64'd0);
    directed("t3_fwd", 32'h0, 32'h2000_0000, 32'h0000_7FFF, 1'b0, 1'b0,
             32'h0000_2000, 32'h0000_E000, 32'h0000_2000);
    directed("t3_inv", 32'h0, 32'h2000_0000, 32'h0000_7FFF, 1'b1, 1'b0,
             32'h0000_E000, 32'h0000_2000, 32'h0000_E000);

    // overflow transfers while clear is held: set wins, then clear alone drops it
    ovf_clear = 1'b1;
    send_beat(32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 8'h66);
    drain();
    chk("t6_set_wins", 64'(ovf_sticky), 64'd1);
    @(posedge clk); #1;
    chk("t6_clear", 64'(ovf_sticky), 64'd0);
    ovf_clear = 1'b0;

    // 8-beat stream, random out_ready with a forced 5-cycle stall
    rdy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      if (t == 4) begin
        rdy_mode = 2;
        fork
          begin
            repeat (5) @(posedge clk);
            rdy_mode = 1;
          end
        join_none
      end
      send_beat($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), TAG_W'(t));
    end
    drain();

    // random traffic with idle gaps, mixed modes and occasional clears
    for (int i = 0; i < 150; i++) begin
      ovf_clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      ra = $urandom; rb = $urandom; rw = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ra = ra & 32'h3FFF_3FFF; rb = rb & 32'h3FFF_3FFF;
      end
      send_beat(ra, rb, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                TAG_W'($urandom));
    end
    ovf_clear = 1'b0;
    drain();

    // reset with three beats in flight
    rdy_mode = 0;
    send_beat(32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 8'h55);
    drain();
    chk("t5_pre_ovf", 64'(ovf_sticky), 64'd1);
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) send_beat($urandom, $urandom, $urandom, 1'b0, 1'b0, TAG_W'(8'hC0 + t));
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_ovf", 64'(ovf_sticky), 64'd0);
    chk("t5_wrap_valid", 64'(w_out_valid), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_after_valid", 64'(out_valid), 64'd0);
    chk("t5_after_ovf", 64'(ovf_sticky), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
